// File: rtl/board_move_arbiter.sv
// board_move_arbiter: runs one move-generation pass over the column units.
// It pulses col_reset, then drains the column FIFOs round-robin, one word
// at a time, into a single output register.
// Optional feature: define BOARD_ARB_WDOG_EN to add a pass watchdog that
// forces FIN and raises err_wdog after WDOG_MAX run-phase cycles.
// Handshake: mv_valid/mv_ready. A word transfers on a clock edge where both
// are high. While mv_valid is high and mv_ready is low, mv_data and mv_col
// are held stable. mv_valid never drops without an accept, except on reset
// or watchdog expiry.
module board_move_arbiter #(
  parameter int W       = 152,
  parameter int NCOL    = 8,
  parameter int CLR_CYC = 2
`ifdef BOARD_ARB_WDOG_EN
  , parameter int WDOG_MAX = 4095
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       col_reset,
  input  logic [NCOL-1:0]            col_done,
  input  logic [NCOL-1:0]            col_empty,
  output logic [NCOL-1:0]            col_rden,
  input  logic [NCOL*W-1:0]          col_data,
  output logic                       mv_valid,
  input  logic                       mv_ready,
  output logic [W-1:0]               mv_data,
  output logic [$clog2(NCOL)-1:0]    mv_col,
  output logic                       busy,
  output logic                       gen_done,
  output logic                       err_wdog,
  output logic [2:0]                 dbg_state
);

  localparam int PW = $clog2(NCOL);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    RD   = 3'd3,
    CAP  = 3'd4,
    OUT  = 3'd5,
    FIN  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      clr_cnt_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   sel_q;
  logic [PW-1:0]   sel_pick;
  logic [NCOL-1:0] req;
  logic            wd_expire;
  logic            run_phase;

  assign req       = ~col_empty;
  assign run_phase = (state_q == RUN) || (state_q == RD) ||
                     (state_q == CAP) || (state_q == OUT);
  assign dbg_state = state_q;

  // Round-robin pick: first requesting column at or after rr_ptr, wrapping.
  always_comb begin
    int   j;
    logic found;
    sel_pick = '0;
    found    = 1'b0;
    j        = 0;
    for (int i = 0; i < NCOL; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NCOL) j = j - NCOL;
      if (!found && req[PW'(j)]) begin
        sel_pick = PW'(j);
        found    = 1'b1;
      end
    end
  end

`ifdef BOARD_ARB_WDOG_EN
  logic [11:0] wd_cnt_q;

  // Watchdog counts run-phase cycles; cleared while in CLR so RUN entry starts at 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt_q <= '0;
    end else if (state_q == CLR) begin
      wd_cnt_q <= '0;
    end else if (run_phase) begin
      wd_cnt_q <= wd_cnt_q + 12'd1;
    end
  end

  assign wd_expire = run_phase && (wd_cnt_q == 12'(WDOG_MAX - 1));
`else
  assign wd_expire = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control outputs.
  always_comb begin
    state_d   = state_q;
    col_reset = 1'b0;
    col_rden  = '0;
    busy      = 1'b0;
    gen_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLR;
      end
      CLR: begin
        col_reset = 1'b1;
        busy      = 1'b1;
        if (clr_cnt_q == 8'(CLR_CYC - 1)) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (wd_expire) begin
          state_d = FIN;
        end else if (req != '0) begin
          col_rden[sel_pick] = 1'b1;
          state_d            = RD;
        end else if ((&col_done) && !mv_valid) begin
          state_d = FIN;
        end
      end
      RD: begin
        busy    = 1'b1;
        state_d = wd_expire ? FIN : CAP;
      end
      CAP: begin
        busy    = 1'b1;
        state_d = wd_expire ? FIN : OUT;
      end
      OUT: begin
        busy = 1'b1;
        if (wd_expire)     state_d = FIN;
        else if (mv_ready) state_d = RUN;
      end
      FIN: begin
        gen_done = 1'b1;
        if (start) state_d = CLR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: clear counter, selected column, output word register, pointer, error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_cnt_q <= '0;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      mv_valid  <= 1'b0;
      mv_data   <= '0;
      mv_col    <= '0;
      err_wdog  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) clr_cnt_q <= '0;
        end
        FIN: begin
          if (start) begin
            clr_cnt_q <= '0;
            err_wdog  <= 1'b0;
          end
        end
        CLR: begin
          clr_cnt_q <= clr_cnt_q + 8'd1;
        end
        RUN: begin
          if (req != '0) sel_q <= sel_pick;
        end
        CAP: begin
          mv_data  <= col_data[int'(sel_q)*W +: W];
          mv_col   <= sel_q;
          mv_valid <= 1'b1;
          rr_ptr_q <= (sel_q == PW'(NCOL - 1)) ? '0 : sel_q + 1'b1;
        end
        OUT: begin
          if (mv_ready) mv_valid <= 1'b0;
        end
        default: ;
      endcase
      if (wd_expire) begin
        mv_valid <= 1'b0;
        err_wdog <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_move_arbiter.sv
// tb_board_move_arbiter: bench for board_move_arbiter (default build).
// Column FIFOs are modelled as queues with one cycle of read latency.
module tb_board_move_arbiter;

  localparam int W    = 152;
  localparam int NCOL = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic              col_reset;
  logic [NCOL-1:0]   col_done;
  logic [NCOL-1:0]   col_empty = '1;
  logic [NCOL-1:0]   col_rden;
  logic [NCOL*W-1:0] col_data;
  logic              mv_valid;
  logic              mv_ready;
  logic [W-1:0]      mv_data;
  logic [2:0]        mv_col;
  logic              busy;
  logic              gen_done;
  logic              err_wdog;
  logic [2:0]        dbg_state;

  board_move_arbiter dut (
    .clk(clk), .reset(reset), .start(start), .col_reset(col_reset),
    .col_done(col_done), .col_empty(col_empty), .col_rden(col_rden),
    .col_data(col_data), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_data(mv_data), .mv_col(mv_col), .busy(busy), .gen_done(gen_done),
    .err_wdog(err_wdog), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- column FIFO model ----------------
  logic [W-1:0] fifo [NCOL][$];
  logic [W-1:0] q_reg [NCOL];

  initial for (int c = 0; c < NCOL; c++) q_reg[c] = '0;

  always @(posedge clk) begin
    for (int c = 0; c < NCOL; c++) begin
      if (col_rden[c] && fifo[c].size() > 0) q_reg[c] <= fifo[c].pop_front();
      col_empty[c] <= (fifo[c].size() == 0);
    end
  end

  always_comb begin
    col_data = '0;
    for (int c = 0; c < NCOL; c++) col_data[c*W +: W] = q_reg[c];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_col_q[$];
  int           m_ptr;
  int           checks;
  int           errors;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: repeatedly take the first non-empty column at or after the
  // pointer (modulo NCOL), one word each time, pointer moves past the winner.
  task automatic model_pass();
    int  taken[NCOL];
    int  c;
    bit  found;
    for (int i = 0; i < NCOL; i++) taken[i] = 0;
    c = 0;
    while (1) begin
      found = 0;
      for (int k = 0; k < NCOL; k++) begin
        c = (m_ptr + k) % NCOL;
        if (taken[c] < fifo[c].size()) begin
          found = 1;
          break;
        end
      end
      if (!found) break;
      exp_q.push_back(fifo[c][taken[c]]);
      exp_col_q.push_back(c);
      taken[c]++;
      m_ptr = (c + 1) % NCOL;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int ready_pct);
    logic         pv, pa;
    logic [W-1:0] pd, ed;
    logic [2:0]   pc;
    int           ec;
    pv = 1'b0; pa = 1'b0; pd = '0; pc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (gen_done) break;
      if (mv_valid) chk("rden_while_valid", W'(col_rden), '0);
      if (col_rden != '0) chk("rden_onehot", W'($onehot(col_rden)), W'(1));
      if (pv && !pa) begin
        chk("hold_valid", W'(mv_valid), W'(1));
        chk("hold_data", mv_data, pd);
        chk("hold_col", W'(mv_col), W'(pc));
      end
      mv_ready = ($urandom_range(99) < ready_pct);
      pa = mv_valid && mv_ready;
      if (pa) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got col %0d data %0h expected no word", mv_col, mv_data);
        end else begin
          ed = exp_q.pop_front();
          ec = exp_col_q.pop_front();
          chk("word_data", mv_data, ed);
          chk("word_col", W'(mv_col), W'(ec));
        end
      end
      pv = mv_valid; pd = mv_data; pc = mv_col;
    end
    mv_ready = 1'b0;
    chk("pass_gen_done", W'(gen_done), W'(1));
    chk("pass_busy_low", W'(busy), W'(0));
    chk("pass_words_left", W'(exp_q.size()), W'(0));
    exp_q.delete();
    exp_col_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mv_valid"}, W'(mv_valid), '0);
    chk({tag, "_mv_data"}, mv_data, '0);
    chk({tag, "_mv_col"}, W'(mv_col), '0);
    chk({tag, "_col_rden"}, W'(col_rden), '0);
    chk({tag, "_col_reset"}, W'(col_reset), '0);
    chk({tag, "_busy"}, W'(busy), '0);
    chk({tag, "_gen_done"}, W'(gen_done), '0);
    chk({tag, "_err_wdog"}, W'(err_wdog), '0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          pre_col;  // one-word pass first, leaves pointer at pre_col+1
    logic [7:0]  mask;     // columns holding one word each
    int          n;        // expected word count
    logic [31:0] seq;      // expected mv_col order, nibble i = i-th word
  } vec_t;

  vec_t tbl[5];

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] w;
    logic [W-1:0] hold;
    int           last;
    int           nw;

    checks = 0; errors = 0; m_ptr = 0;
    start = 1'b0; mv_ready = 1'b0; col_done = 8'hFF; reset = 1'b0;

    tbl[0] = '{3, 8'b1000_1001, 3, 32'h0000_0307};
    tbl[1] = '{7, 8'b0101_0010, 3, 32'h0000_0641};
    tbl[2] = '{5, 8'b0100_0001, 2, 32'h0000_0006};
    tbl[3] = '{2, 8'b0000_0111, 3, 32'h0000_0210};
    tbl[4] = '{0, 8'b1111_1111, 8, 32'h0765_4321};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Col 1 holds A1, A2; col_reset timing and first read latency.
    fifo[1].push_back(W'(32'hA1));
    fifo[1].push_back(W'(32'hA2));
    exp_q.push_back(W'(32'hA1)); exp_col_q.push_back(1);
    exp_q.push_back(W'(32'hA2)); exp_col_q.push_back(1);
    m_ptr = 2;
    start_pass();
    chk("t2_col_reset_c1", W'(col_reset), W'(1));
    chk("t2_busy_c1", W'(busy), W'(1));
    @(negedge clk);
    chk("t2_col_reset_c2", W'(col_reset), W'(1));
    chk("t2_rden_c2", W'(col_rden), '0);
    @(negedge clk);
    chk("t2_col_reset_c3", W'(col_reset), W'(0));
    chk("t2_first_rden", W'(col_rden), W'(8'b0000_0010));
    drain(100);

    // Round-robin order table.
    foreach (tbl[t]) begin
      fifo[tbl[t].pre_col].push_back(W'(32'hEE00 + tbl[t].pre_col));
      model_pass();
      start_pass();
      drain(100);
      last = 0;
      for (int c = 0; c < NCOL; c++)
        if (tbl[t].mask[c]) fifo[c].push_back(W'(32'hD000 + c));
      for (int i = 0; i < tbl[t].n; i++) begin
        last = int'(tbl[t].seq[4*i +: 4]);
        exp_q.push_back(W'(32'hD000 + last));
        exp_col_q.push_back(last);
      end
      m_ptr = (last + 1) % NCOL;
      start_pass();
      drain(80);
    end

    // First word stalled 10 cycles: data stable, no reads.
    fifo[4].push_back(W'(32'hC41));
    fifo[4].push_back(W'(32'hC42));
    model_pass();
    start_pass();
    for (int i = 0; i < 20 && !mv_valid; i++) @(negedge clk);
    chk("t4_valid", W'(mv_valid), W'(1));
    chk("t4_first_data", mv_data, W'(32'hC41));
    hold = mv_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_data", mv_data, hold);
      chk("t4_no_rden", W'(col_rden), '0);
    end
    drain(100);

    // Done already high with a column still holding 3 words.
    for (int k = 0; k < 3; k++) fifo[5].push_back(W'(32'hF50 + k));
    model_pass();
    start_pass();
    drain(50);

    // All empty, not all done: no reads, no completion; start is ignored.
    col_done = 8'h00;
    start_pass();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 10) start = 1'b1;
      if (i == 11) begin
        start = 1'b0;
        chk("ign_start_no_clr", W'(col_reset), W'(0));
      end
      chk("stall_no_rden", W'(col_rden), '0);
      chk("stall_no_done", W'(gen_done), W'(0));
    end
    col_done = 8'hFF;
    for (int i = 0; i < 5 && !gen_done; i++) @(negedge clk);
    chk("stall_release_done", W'(gen_done), W'(1));

    // Randomized passes against the reference model.
    for (int p = 0; p < 20; p++) begin
      for (int c = 0; c < NCOL; c++) begin
        nw = $urandom_range(0, 3);
        for (int k = 0; k < nw; k++) begin
          w = '0;
          for (int b = 0; b < 5; b++) w = (w << 32) | W'($urandom);
          fifo[c].push_back(w);
        end
      end
      model_pass();
      start_pass();
      drain($urandom_range(30, 100));
    end

    // Reset mid-pass while a word is held in OUT.
    fifo[2].push_back(W'(32'hB1));
    fifo[2].push_back(W'(32'hB2));
    start_pass();
    for (int i = 0; i < 20 && !mv_valid; i++) @(negedge clk);
    chk("t1_valid_before", W'(mv_valid), W'(1));
    chk("t1_col_before", W'(mv_col), W'(2));
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("t1_after_reset");
    reset = 1'b1;
    m_ptr = 0;
    exp_q.push_back(W'(32'hB2)); exp_col_q.push_back(2);
    m_ptr = 3;
    start_pass();
    drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
